// File: rtl/gates_pkg.sv
// gates_pkg: constants and helpers shared by the gate-driving front-end blocks.
// Used by debounce_channel and input_debouncer. The optional edge-pulse
// outputs of those blocks are enabled by defining DEBOUNCE_PULSE_EN.
package gates_pkg;

    // 10 ms of settling time at a 100 MHz system clock.
    localparam int DEBOUNCE_DEFAULT_CYCLES = 1000000;

    // Width needed for a counter that runs from 0 up to count-1.
    // Equivalent to $clog2(count), but never returns less than 1 so a
    // degenerate count of 1 still yields a legal one-bit register.
    function automatic int counter_width(input int count);
        int width;
        width = 1;
        while ((64'd1 << width) < 64'(count)) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one channel of the input debouncer.
// A raw asynchronous input passes through a 2-flop synchronizer. A new
// level is accepted onto dout only after the synchronized value has differed
// from dout for STABLE_CYCLES consecutive clocks. Any sample that agrees with
// dout restarts the count, so bounces shorter than that never get through.
// With DEBOUNCE_PULSE_EN defined, registered one-cycle rise/fall pulses
// accompany each accepted change of dout.
import gates_pkg::*;

module debounce_channel #(
    parameter int STABLE_CYCLES = DEBOUNCE_DEFAULT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
`ifdef DEBOUNCE_PULSE_EN
    ,
    output logic rise,
    output logic fall
`endif
);

    localparam int CNT_W = counter_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             sync0;
    logic             sync1;
    logic [CNT_W-1:0] cnt;
    logic             differs;
    logic             accept;

    // The synchronized level disagrees with dout; on the last counted cycle
    // that disagreement is accepted as the new level.
    assign differs = (sync1 != dout);
    assign accept  = differs && (cnt == CNT_LAST);

    // Two-flop synchronizer bringing the asynchronous input into the clk domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
        end else begin
            sync0 <= din;
            sync1 <= sync0;
        end
    end

    // Stability counter and accepted output level; the count never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            dout <= 1'b0;
        end else if (!differs) begin
            cnt  <= '0;
        end else if (accept) begin
            cnt  <= '0;
            dout <= sync1;
        end else begin
            cnt  <= cnt + CNT_W'(1);
        end
    end

`ifdef DEBOUNCE_PULSE_EN
    // Edge pulses registered on the same edge that changes dout.
    always_ff @(posedge clk) begin
        if (rst) begin
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= accept &&  sync1;
            fall <= accept && !sync1;
        end
    end
`endif

endmodule

// File: rtl/input_debouncer.sv
// input_debouncer: WIDTH independent debounced inputs feeding the gate
// modules (dout[0] drives A, dout[1] drives B). Each bit is handled by its
// own debounce_channel, so channels that change together still produce
// their own pulses. Define DEBOUNCE_PULSE_EN to add the rise/fall ports;
// dout timing is identical with or without them.
import gates_pkg::*;

module input_debouncer #(
    parameter int WIDTH         = 2,
    parameter int STABLE_CYCLES = DEBOUNCE_DEFAULT_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
`ifdef DEBOUNCE_PULSE_EN
    ,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
`endif
);

    // One self-contained debounce channel per input bit.
    for (genvar i = 0; i < WIDTH; i++) begin : g_channel
        debounce_channel #(
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_channel (
            .clk (clk),
            .rst (rst),
            .din (din[i]),
            .dout(dout[i])
`ifdef DEBOUNCE_PULSE_EN
            ,
            .rise(rise[i]),
            .fall(fall[i])
`endif
        );
    end

endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: directed scenarios with hand-derived timing plus a
// randomized run compared against a window-based reference model.
// Pulse outputs are exercised when DEBOUNCE_PULSE_EN is defined.
module tb_input_debouncer;

    localparam int WIDTH = 2;
    localparam int S     = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] din = '0;
    logic [WIDTH-1:0] dout;
`ifdef DEBOUNCE_PULSE_EN
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: din reaches the filter two edges late; a channel
    // flips when the last S filter samples all disagree with its output.
    logic [WIDTH-1:0] m_dly0 = '0;
    logic [WIDTH-1:0] m_dly1 = '0;
    logic [WIDTH-1:0] m_win [0:S-1];
    int               m_fill = 0;
    logic [WIDTH-1:0] m_dout = '0;
    logic [WIDTH-1:0] m_rise = '0;
    logic [WIDTH-1:0] m_fall = '0;

    input_debouncer #(
        .WIDTH        (WIDTH),
        .STABLE_CYCLES(S)
    ) dut (
        .clk (clk),
        .rst (rst),
        .din (din),
        .dout(dout)
`ifdef DEBOUNCE_PULSE_EN
        ,
        .rise(rise),
        .fall(fall)
`endif
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    task automatic model_update();
        logic [WIDTH-1:0] seen;
        logic             all_differ;
        if (rst) begin
            m_dly0 = '0;
            m_dly1 = '0;
            m_fill = 0;
            m_dout = '0;
            m_rise = '0;
            m_fall = '0;
        end else begin
            seen   = m_dly1;
            m_dly1 = m_dly0;
            m_dly0 = din;
            for (int j = S - 1; j > 0; j--) m_win[j] = m_win[j-1];
            m_win[0] = seen;
            if (m_fill < S) m_fill = m_fill + 1;
            m_rise = '0;
            m_fall = '0;
            for (int i = 0; i < WIDTH; i++) begin
                all_differ = (m_fill == S);
                for (int j = 0; j < S; j++) begin
                    if (m_win[j][i] == m_dout[i]) all_differ = 1'b0;
                end
                if (all_differ) begin
                    m_dout[i] = ~m_dout[i];
                    if (m_dout[i]) m_rise[i] = 1'b1;
                    else           m_fall[i] = 1'b1;
                end
            end
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset(input logic [WIDTH-1:0] level);
        rst = 1'b1;
        din = level;
        repeat (3) step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [WIDTH-1:0] exp_d, exp_r;
        rst = 1'b1;
        din = 2'b11;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (dout !== 2'b00) begin
                errors++;
                $display("[TB] FAIL reset_hold: dout=%b expected 00", dout);
            end
`ifdef DEBOUNCE_PULSE_EN
            checks++;
            if (rise !== 2'b00 || fall !== 2'b00) begin
                errors++;
                $display("[TB] FAIL reset_hold_pulse: rise=%b fall=%b expected 00/00", rise, fall);
            end
`endif
        end
        rst = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            step();
            exp_d = (i >= 6) ? 2'b11 : 2'b00;
            exp_r = (i == 6) ? 2'b11 : 2'b00;
            checks++;
            if (dout !== exp_d) begin
                errors++;
                $display("[TB] FAIL reset_release R0+%0d: dout=%b expected %b", i - 1, dout, exp_d);
            end
`ifdef DEBOUNCE_PULSE_EN
            checks++;
            if (rise !== exp_r || fall !== 2'b00) begin
                errors++;
                $display("[TB] FAIL reset_release_pulse R0+%0d: rise=%b fall=%b expected %b/00", i - 1, rise, fall, exp_r);
            end
`endif
        end
    endtask

    task automatic test_clean_press();
        logic [WIDTH-1:0] exp_d, exp_r;
        do_reset(2'b00);
        din = 2'b01;
        for (int i = 1; i <= 8; i++) begin
            step();
            exp_d = (i >= 6) ? 2'b01 : 2'b00;
            exp_r = (i == 6) ? 2'b01 : 2'b00;
            checks++;
            if (dout !== exp_d) begin
                errors++;
                $display("[TB] FAIL clean_press E0+%0d: dout=%b expected %b", i - 1, dout, exp_d);
            end
`ifdef DEBOUNCE_PULSE_EN
            checks++;
            if (rise !== exp_r || fall !== 2'b00) begin
                errors++;
                $display("[TB] FAIL clean_press_pulse E0+%0d: rise=%b fall=%b expected %b/00", i - 1, rise, fall, exp_r);
            end
`endif
        end
    endtask

    task automatic test_glitch();
        logic [WIDTH-1:0] exp_d, exp_r;
        do_reset(2'b00);
        din = 2'b01;
        repeat (3) step();
        din = 2'b00;
        for (int i = 1; i <= 8; i++) begin
            step();
            checks++;
            if (dout !== 2'b00) begin
                errors++;
                $display("[TB] FAIL glitch_3: dout=%b expected 00", dout);
            end
`ifdef DEBOUNCE_PULSE_EN
            checks++;
            if (rise !== 2'b00 || fall !== 2'b00) begin
                errors++;
                $display("[TB] FAIL glitch_3_pulse: rise=%b fall=%b expected 00/00", rise, fall);
            end
`endif
        end
        din = 2'b01;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i == 4) din = 2'b00;
            exp_d = (i >= 6) ? 2'b01 : 2'b00;
            exp_r = (i == 6) ? 2'b01 : 2'b00;
            checks++;
            if (dout !== exp_d) begin
                errors++;
                $display("[TB] FAIL glitch_4 E0+%0d: dout=%b expected %b", i - 1, dout, exp_d);
            end
`ifdef DEBOUNCE_PULSE_EN
            checks++;
            if (rise !== exp_r) begin
                errors++;
                $display("[TB] FAIL glitch_4_pulse E0+%0d: rise=%b expected %b", i - 1, rise, exp_r);
            end
`endif
        end
    endtask

    task automatic test_bounce();
        logic [4:0]       pattern;
        logic [WIDTH-1:0] exp_d;
        int               rise_count;
        pattern    = 5'b01101;
        rise_count = 0;
        do_reset(2'b00);
        for (int k = 0; k < 5; k++) begin
            din = {1'b0, pattern[k]};
            step();
            checks++;
            if (dout !== 2'b00) begin
                errors++;
                $display("[TB] FAIL bounce_early: dout=%b expected 00", dout);
            end
        end
        din = 2'b01;
        for (int i = 1; i <= 10; i++) begin
            step();
            exp_d = (i >= 6) ? 2'b01 : 2'b00;
            checks++;
            if (dout !== exp_d) begin
                errors++;
                $display("[TB] FAIL bounce Es+%0d: dout=%b expected %b", i - 1, dout, exp_d);
            end
`ifdef DEBOUNCE_PULSE_EN
            if (rise[0] === 1'b1) rise_count++;
`endif
        end
`ifdef DEBOUNCE_PULSE_EN
        checks++;
        if (rise_count != 1) begin
            errors++;
            $display("[TB] FAIL bounce_rise_count: got %0d expected 1", rise_count);
        end
`endif
    endtask

    task automatic test_release();
        logic [WIDTH-1:0] exp_d, exp_f;
        do_reset(2'b11);
        repeat (7) step();
        din = 2'b00;
        for (int i = 1; i <= 8; i++) begin
            step();
            exp_d = (i >= 6) ? 2'b00 : 2'b11;
            exp_f = (i == 6) ? 2'b11 : 2'b00;
            checks++;
            if (dout !== exp_d) begin
                errors++;
                $display("[TB] FAIL release E0+%0d: dout=%b expected %b", i - 1, dout, exp_d);
            end
`ifdef DEBOUNCE_PULSE_EN
            checks++;
            if (fall !== exp_f || rise !== 2'b00) begin
                errors++;
                $display("[TB] FAIL release_pulse E0+%0d: fall=%b rise=%b expected %b/00", i - 1, fall, rise, exp_f);
            end
`endif
        end
    endtask

    task automatic test_reset_mid_count();
        logic [WIDTH-1:0] exp_d, exp_r;
        do_reset(2'b00);
        din = 2'b01;
        repeat (4) step();
        rst = 1'b1;
        step();
        checks++;
        if (dout !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_mid_hold: dout=%b expected 00", dout);
        end
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
            exp_d = (i >= 6) ? 2'b01 : 2'b00;
            exp_r = (i == 6) ? 2'b01 : 2'b00;
            checks++;
            if (dout !== exp_d) begin
                errors++;
                $display("[TB] FAIL reset_mid R0+%0d: dout=%b expected %b", i - 1, dout, exp_d);
            end
`ifdef DEBOUNCE_PULSE_EN
            checks++;
            if (rise !== exp_r) begin
                errors++;
                $display("[TB] FAIL reset_mid_pulse R0+%0d: rise=%b expected %b", i - 1, rise, exp_r);
            end
`endif
        end
    endtask

    task automatic test_random();
        int hold;
        hold = 0;
        do_reset(WIDTH'($urandom));
        for (int n = 0; n < 2000; n++) begin
            rst = ($urandom_range(0, 249) == 0);
            if (hold == 0) begin
                din  = WIDTH'($urandom);
                hold = $urandom_range(1, 8);
            end
            hold--;
            step();
            checks++;
            if (dout !== m_dout) begin
                errors++;
                $display("[TB] FAIL random cycle %0d: dout=%b expected %b", n, dout, m_dout);
            end
`ifdef DEBOUNCE_PULSE_EN
            checks++;
            if (rise !== m_rise || fall !== m_fall) begin
                errors++;
                $display("[TB] FAIL random_pulse cycle %0d: rise=%b fall=%b expected %b/%b", n, rise, fall, m_rise, m_fall);
            end
`endif
        end
        rst = 1'b0;
    endtask

    initial begin
        for (int j = 0; j < S; j++) m_win[j] = '0;
        test_reset();
        test_clean_press();
        test_glitch();
        test_bounce();
        test_release();
        test_reset_mid_count();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/input_debouncer.md
# input_debouncer

Synchronizes and debounces WIDTH raw asynchronous inputs (push-buttons/switches) and presents clean, glitch-free levels that drive the A/B inputs of the combinational gate modules. It is the upstream stage for every gate in the design. A channel's output changes only after its input has held a new level for STABLE_CYCLES consecutive clocks. Optional single-cycle edge pulses are available.

## Interface
- WIDTH, 2: number of independent channels (≥1).
- STABLE_CYCLES, 1000000: consecutive synchronized clocks a new level must persist before it is accepted (≥1). The default gives 10 ms at 100 MHz.
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  WIDTH  raw asynchronous inputs.
- dout  output  WIDTH  debounced registered levels; dout[0] feeds A and dout[1] feeds B of the downstream gate.
- rise  output  WIDTH  one-cycle pulse when dout[i] goes 0→1 (present only with DEBOUNCE_PULSE_EN).
- fall  output  WIDTH  one-cycle pulse when dout[i] goes 1→0 (present only with DEBOUNCE_PULSE_EN).

## Operation
- Clock and reset are fixed: one clock `clk`, with `rst` synchronous and active-high.
- Each channel is fully independent. It holds:
  - sync0 and sync1, a 2-flop synchronizer;
  - cnt, a counter of width $clog2(STABLE_CYCLES) (min 1);
  - out, the registered output.
- On each edge with rst=1, all registers clear: sync0, sync1, cnt, out, rise and fall all go to 0. The rst input itself is not synchronized.
- On each edge with rst=0:
  - sync0←din[i] and sync1←sync0.
  - If sync1==out: cnt←0.
  - Else if cnt==STABLE_CYCLES-1: out←sync1 and cnt←0.
  - Else cnt←cnt+1.
- Any sample of sync1 equal to out restarts the count. Glitches and bounces shorter than STABLE_CYCLES never reach dout.
- The counter never wraps. It is bounded by STABLE_CYCLES-1 and cleared on acceptance.
- Pulses are registered in the same edge that updates out:
  - rise[i]=1 exactly when out transitions 0→1 on that edge;
  - fall[i]=1 exactly when out transitions 1→0;
  - otherwise both are 0.
  - rise and fall are never both high on the same channel.
- Channels changing on the same edge update independently. Each channel produces its own pulse.
- No handshake is used: dout is level-valid every cycle.

## Timing
- Reset values: dout=0, rise=0, fall=0.
- Latency: let din[i] change with setup met before edge E0, then stay stable.
  - dout[i] changes at edge E0+STABLE_CYCLES+1.
  - With STABLE_CYCLES=1, it changes at E0+2 (pure 2-flop synchronizer).
- A pulse is high for exactly the one cycle following the edge on which dout changes.
- Reset mid-count: a rst edge discards partial counts and synchronizer contents.
  - Take the first edge with rst=0 as R0, with din held constant through reset.
  - A level that differs from 0 is accepted at R0+STABLE_CYCLES+1.
- Reset while din=1: dout stays 0 during rst, then rises per the rule above.

## Configuration
- DEBOUNCE_PULSE_EN defined: the rise and fall ports and their registers exist, behaving as above.
- DEBOUNCE_PULSE_EN undefined: the rise and fall ports and their logic are omitted. dout behaviour is cycle-identical in both builds.

## Structure
- Shared package gates_pkg holds:
  - constant DEBOUNCE_DEFAULT_CYCLES (1000000);
  - a clog2-style width helper, used for cnt and reused by future counters in the codebase.
- Sub-module debounce_channel implements one channel (synchronizer, counter, out, optional pulses). input_debouncer instantiates it WIDTH times with a generate loop.

## Test plan
All scenarios use WIDTH=2 and STABLE_CYCLES=4.
- Reset: rst=1 for 3 cycles with din=2'b11 → dout=00, rise=00, fall=00 throughout. After release, dout=11 at R0+5 and rise=11 for one cycle.
- Clean press: din[0] 0→1 before E0 and held → dout[0]=1 at E0+5, rise[0]=1 for one cycle only. dout[1], rise[1] and fall[1] stay 0.
- Glitch: din[0]=1 for 3 cycles then back to 0 → dout[0] stays 0, no pulse. A 4-cycle high is accepted at E0+5.
- Bounce: din[0] sequence 1,0,1,1,0, then steady 1 from edge Es → dout[0]=1 at Es+5, exactly one rise[0] pulse.
- Release and simultaneity: with dout=11, din→00 before E0 → dout=00 at E0+5 and fall=11 on the same cycle.
- Reset mid-count: din[0]=1 and rst asserted when cnt=2 → cnt clears and dout[0] stays 0. Acceptance occurs at R0+5, not earlier.
